// File: rtl/rs_pkg.sv
// Shared Reed-Solomon helpers: field polynomials per symbol width,
// elaboration-time GF(2^m) constant multiplication, and code-length helpers.
package rs_pkg;

  // Default primitive field polynomial for a given symbol width
  function automatic int prim_poly_for(input int bw);
    case (bw)
      3:       return 'h00B;
      4:       return 'h013;
      5:       return 'h025;
      6:       return 'h043;
      7:       return 'h089;
      default: return 'h11D;
    endcase
  endfunction

  // x * alpha^p in the field defined by poly, evaluated while elaborating.
  // After a left shift, (v ^ poly) < v holds exactly when v carries the
  // polynomial's top bit, which is the reduction condition.
  function automatic int gf_mul_alpha_pow(input int x, input int p, input int poly);
    int v;
    v = x;
    for (int i = 0; i < p; i++) begin
      v = v << 1;
      if ((v ^ poly) < v) v = v ^ poly;
    end
    return v;
  endfunction

  // Message symbols per codeword
  function automatic int k_num(input int n, input int r);
    return n - r;
  endfunction

endpackage

// File: rtl/rs_syn_cell.sv
// One Horner syndrome cell: S <= S*alpha^ROOT_POW ^ din, or S <= din on the
// first symbol of a codeword. The constant multiplier is a fixed XOR network.
module rs_syn_cell
  import rs_pkg::*;
#(
  parameter int SYM_BW    = 8,
  parameter int ROOT_POW  = 1,
  parameter int PRIM_POLY = prim_poly_for(SYM_BW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [SYM_BW-1:0] din,
  output logic [SYM_BW-1:0] syn
);

  localparam int MW = SYM_BW * SYM_BW;

  // Column i is alpha^ROOT_POW times basis vector 2^i
  function automatic logic [MW-1:0] build_mtx();
    logic [MW-1:0] m;
    int            col;
    m = '0;
    for (int i = 0; i < SYM_BW; i++) begin
      col = gf_mul_alpha_pow(1 << i, ROOT_POW, PRIM_POLY);
      for (int b = 0; b < SYM_BW; b++) m[i*SYM_BW+b] = col[b];
    end
    return m;
  endfunction

  localparam logic [MW-1:0] MTX = build_mtx();

  logic [SYM_BW-1:0] scaled;

  // Constant multiply of the current syndrome by alpha^ROOT_POW
  always_comb begin
    scaled = '0;
    for (int i = 0; i < SYM_BW; i++) begin
      if (syn[i]) scaled = scaled ^ MTX[i*SYM_BW +: SYM_BW];
    end
  end

  // Horner accumulation, restarted by the first symbol of a codeword
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  syn <= '0;
    else if (en) syn <= load ? din : (scaled ^ din);
  end

endmodule

// File: rtl/rs_syn_chk.sv
// RS receive-side syndrome checker: computes R_NUM syndromes per codeword,
// buffers the message symbols in a two-bank ping-pong store and replays
// them as a framed stream tagged with the codeword's error flag.
module rs_syn_chk
  import rs_pkg::*;
#(
  parameter int SYM_BW    = 8,
  parameter int N_NUM     = 255,
  parameter int R_NUM     = 32,
  parameter int PRIM_POLY = prim_poly_for(SYM_BW)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    din_val,
  input  logic                    din_sop,
  input  logic [SYM_BW-1:0]       din,
  output logic                    syn_val,
  output logic                    syn_err,
  output logic [R_NUM*SYM_BW-1:0] syn_bus,
  output logic                    dout_val,
  output logic                    dout_sop,
  output logic                    dout_eop,
  output logic [SYM_BW-1:0]       dout,
  output logic                    dout_err
);

  // K_NUM >= 2 is assumed: the reader emits symbol 0 from IDLE.
  localparam int K_NUM = k_num(N_NUM, R_NUM);
  localparam int CNT_W = $clog2(N_NUM + 1);
  localparam int IDX_W = $clog2(K_NUM);
  localparam int ADR_W = $clog2(2 * K_NUM);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;

  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        idx;
  logic                    accept;
  logic                    last;
  logic                    wr_en;
  logic                    wr_bank;
  logic [ADR_W-1:0]        wr_addr;
  logic [R_NUM*SYM_BW-1:0] syn_cells;
  logic [R_NUM*SYM_BW-1:0] syn_hold;
  logic                    vld_p0;
  logic                    fin_bank_p0;
  logic [1:0]              bank_full;
  logic [1:0]              bank_err;
  logic [SYM_BW-1:0]       mem [2*K_NUM];
  logic [0:0]              state;
  logic                    rd_bank;
  logic [IDX_W-1:0]        rd_idx;
  logic [ADR_W-1:0]        rd_addr;
  logic                    play_now;
  logic                    play_last;

  // A sop always restarts a codeword; other symbols count only mid-codeword
  assign accept  = din_val && (din_sop || (cnt != '0));
  assign idx     = din_sop ? '0 : cnt;
  assign last    = accept && (idx == CNT_W'(N_NUM - 1));
  assign wr_en   = accept && (idx < CNT_W'(K_NUM));
  assign wr_addr = ADR_W'(idx) + (wr_bank ? ADR_W'(K_NUM) : ADR_W'(0));

  for (genvar j = 0; j < R_NUM; j++) begin : g_cell
    rs_syn_cell #(
      .SYM_BW    (SYM_BW),
      .ROOT_POW  (j + 1),
      .PRIM_POLY (PRIM_POLY)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (accept),
      .load  (din_sop),
      .din   (din),
      .syn   (syn_cells[j*SYM_BW +: SYM_BW])
    );
  end

  // Symbol counter: 0 is idle, otherwise the number of symbols taken so far
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (accept) cnt <= last ? '0 : idx + CNT_W'(1);
  end

  // Write bank flips as soon as the last symbol lands, so a sop on the very
  // next cycle already writes into the other bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    wr_bank <= 1'b0;
    else if (last) wr_bank <= ~wr_bank;
  end

  // Message store; contents are only meaningful while a bank is marked full
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
  end

  // ---- stage p0: syndromes final, strobe them and note the finished bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0      <= 1'b0;
      fin_bank_p0 <= 1'b0;
    end else begin
      vld_p0 <= last;
      if (last) fin_bank_p0 <= wr_bank;
    end
  end

  // Keep the reported syndromes stable after the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      syn_hold <= '0;
    else if (vld_p0) syn_hold <= syn_cells;
  end

  assign syn_val = vld_p0;
  assign syn_err = vld_p0 && (syn_cells != '0);
  assign syn_bus = vld_p0 ? syn_cells : syn_hold;

  assign rd_addr   = ADR_W'(rd_idx) + (rd_bank ? ADR_W'(K_NUM) : ADR_W'(0));
  assign play_now  = (state == ST_PLAY) || bank_full[rd_bank];
  assign play_last = play_now && (rd_idx == IDX_W'(K_NUM - 1));

  // Reader FSM plus bank bookkeeping; a bank fill is recorded after any
  // release in the same cycle so the two never cancel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rd_idx    <= '0;
      rd_bank   <= 1'b0;
      bank_full <= '0;
      bank_err  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bank_full[rd_bank]) begin
            state  <= ST_PLAY;
            rd_idx <= IDX_W'(1);
          end
        end
        ST_PLAY: begin
          if (play_last) begin
            state   <= ST_IDLE;
            rd_idx  <= '0;
            rd_bank <= ~rd_bank;
          end else begin
            rd_idx <= rd_idx + IDX_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (play_last) bank_full[rd_bank] <= 1'b0;
      if (vld_p0) begin
        bank_full[fin_bank_p0] <= 1'b1;
        bank_err[fin_bank_p0]  <= syn_err;
      end
    end
  end

  assign dout_val = play_now;
  assign dout_sop = play_now && (rd_idx == '0);
  assign dout_eop = play_last;
  assign dout     = play_now ? mem[rd_addr] : '0;
  assign dout_err = play_now && bank_err[rd_bank];

endmodule
